// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Brief    : Request/result bundle between the op decoder and seq_divider.
// Revision : 1.0  initial release
// ============================================================================
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Multi-cycle restoring shift-subtract divider, one quotient bit per
//            clock, MSB first. Define SEQ_DIV_SIGNED_EN for two's-complement.
// Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  seq_divider_if.slave  bus
);

  localparam int              CW         = $clog2(WIDTH) + 1;
  localparam logic [1:0]      c_st_idle  = 2'd0;
  localparam logic [1:0]      c_st_calc  = 2'd1;
  localparam logic [1:0]      c_st_done  = 2'd2;
  localparam logic [CW-1:0]   c_last     = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_dz;
  logic [WIDTH-1:0] w_n_mag;
  logic [WIDTH-1:0] w_d_mag;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Start is only honoured outside CALC, which also covers the DONE re-accept.
  assign w_accept = bus.start && (r_state != c_st_calc);
  assign w_dz     = (bus.divisor == '0);

`ifdef SEQ_DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_n_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_d_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign w_q_fix = r_neg_q ? -w_q_next : w_q_next;
  assign w_r_fix = r_neg_r ? -w_r_next : w_r_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept && !w_dz) begin
      r_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      r_neg_r <= bus.dividend[WIDTH-1];
    end
  end
`else
  assign w_n_mag = bus.dividend;
  assign w_d_mag = bus.divisor;
  assign w_q_fix = w_q_next;
  assign w_r_fix = w_r_next;
`endif

  // Partial remainder stays below the divisor, so WIDTH bits hold it between steps.
  assign w_trial  = {r_r, r_q[WIDTH-1]};
  assign w_ge     = (w_trial >= {1'b0, r_d});
  assign w_r_next = WIDTH'(w_ge ? (w_trial - {1'b0, r_d}) : w_trial);
  assign w_q_next = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_calc: if (r_cnt == c_last) w_next_state = c_st_done;
      default: begin
        if (bus.start) w_next_state = w_dz ? c_st_done : c_st_calc;
        else           w_next_state = c_st_idle;
      end
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      c_st_calc: bus.busy = 1'b1;
      c_st_done: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_q           <= '0;
      r_r           <= '0;
      r_d           <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (w_dz) begin
        r_quotient    <= '1;
        r_remainder   <= bus.dividend;
        r_div_by_zero <= 1'b1;
      end else begin
        r_q           <= w_n_mag;
        r_r           <= '0;
        r_d           <= w_d_mag;
        r_cnt         <= '0;
        r_div_by_zero <= 1'b0;
      end
    end else if (r_state == c_st_calc) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_last) begin
        r_quotient  <= w_q_fix;
        r_remainder <= w_r_fix;
      end
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
